rob_commit: RTL and testbench
=============================

# rob_commit

In-order commit buffer that is the sole writer of the integer register file. It allocates a slot per dispatched instruction in program order and accepts execution results out of order, tagged by slot. It retires completed entries strictly in order, at most one per cycle, driving the register file write port (`write_or_not` / `writeaddr` / `writedata`). It sits between dispatch/execute and the register file, and `flush` discards all speculative state.

## Interface
Parameters:
- `DEPTH`, default 8: number of entries; power of two, ≥2.
- `TAG_W`, default 3: log2(`DEPTH`); width of slot tags.

Ports:
- `clk_in`  in  1: clock, rising-edge.
- `rst_in`  in  1: reset, synchronous, active-high.
- `flush`  in  1: discard all entries (mispredict).
- `alloc_valid`  in  1: dispatch requests a slot this cycle.
- `alloc_rd`  in  5: destination register of the dispatched instruction; 0 means no write.
- `alloc_ready`  out  1: a slot is free (`count != DEPTH`).
- `alloc_tag`  out  TAG_W: tag given to the allocation this cycle (current tail).
- `cmpl_valid`  in  1: a result is being returned.
- `cmpl_tag`  in  TAG_W: slot the result belongs to.
- `cmpl_data`  in  32: result value.
- `write_or_not`  out  1: register file write enable (registered).
- `writeaddr`  out  5: register file write address (registered).
- `writedata`  out  32: register file write data (registered).
- `commit_valid`  out  1: one entry retired this cycle, including rd=0 entries (registered).
- `count`  out  TAG_W+1: number of occupied entries (registered).

## Operation
- Storage per entry: `busy`, `ready`, `rd[4:0]`, `data[31:0]`. Pointers `head` and `tail` are TAG_W bits wide and wrap modulo `DEPTH`.
- Allocate: when `alloc_valid && alloc_ready`, at the edge the tail entry gets busy=1, ready=0, rd=`alloc_rd`; `tail`++. An allocation while `alloc_ready`=0 is ignored.
- `alloc_ready` is combinational from the registered `count`. It does not credit a commit happening in the same cycle, so with `count`=DEPTH it stays 0 even while the head retires.
- Complete: when `cmpl_valid` hits an entry with busy=1 and ready=0, set ready=1 and data=`cmpl_data`. A completion to a non-busy or already-ready entry is ignored.
- Commit: if the head entry has busy=1 and ready=1 before the edge:
  - at the edge, `commit_valid`=1, `writeaddr`=rd, `writedata`=data, `write_or_not`=(rd!=0);
  - the head entry is cleared and `head`++.
  - Otherwise all commit outputs are 0 for the following cycle.
- Simultaneous alloc, complete and commit in one cycle are all honored.
- `count` update per edge: +1 on accepted alloc, −1 on commit.
- `flush` (priority over everything except `rst_in`):
  - all busy/ready bits cleared; `head`=`tail`=0; `count`=0;
  - commit outputs forced to 0 for the next cycle;
  - same-cycle alloc, complete and commit are discarded.
- Reset, including mid-operation, has the same effect as flush. Reset values: `write_or_not`=0, `writeaddr`=0, `writedata`=0, `commit_valid`=0, `count`=0, `alloc_tag`=0, `alloc_ready`=1.

## Timing
- Alloc → entry visible one edge later. `alloc_tag` is valid in the same cycle as `alloc_valid`.
- Completion at edge E sets ready. The commit edge is E+1, and the write is presented to the register file during the cycle after E+1; the register file captures it at E+2.
- Throughput: one commit per cycle. Back-to-back ready entries retire on consecutive edges.
- Full → not full: after a commit edge, `alloc_ready` rises in the next cycle.
- Wrap-around: `alloc_tag` goes from DEPTH−1 to 0 with no bubble.

## Configuration
- `ROB_BYPASS_EN` defined: a completion whose `cmpl_tag`==`head`, for a busy, not-ready head entry, commits at the same edge E.
  - `writedata`=`cmpl_data`; saves one cycle.
  - The entry is freed at that edge.
  - `flush` still suppresses it.
- `ROB_BYPASS_EN` undefined: the completion is written to the entry first and commits at E+1, as above.

## Test plan
- Reset held 2 cycles, then released → all registered outputs 0, `count`=0, `alloc_ready`=1, `alloc_tag`=0.
- Out-of-order completion:
  - stimulus: alloc rd=1,2,3 (tags 0,1,2); complete tag2=0x33, then tag0=0x11, then tag1=0x22 on successive cycles;
  - required: writes x1=0x11, x2=0x22, x3=0x33 in that order; the x2 and x3 writes land on consecutive cycles.
- Full and wrap:
  - stimulus: 8 allocs; then an alloc attempt while full;
  - required: after the 8 allocs `count`=8 and `alloc_ready`=0; the attempt is ignored (`count` stays 8);
  - stimulus: complete and commit tag0;
  - required: `alloc_ready`=1 the cycle after, and the next allocation receives tag0.
- Flush:
  - stimulus: 5 pending entries, head completed; assert `flush`;
  - required: no `write_or_not` in the following cycle; `count`=0; the next alloc gets tag 0; a stale completion to tag 3 is ignored.
- rd=0 entry: alloc rd=0, complete 0xDEAD → `commit_valid`=1, `write_or_not`=0.
- Head completion latency:
  - stimulus: single entry, complete at edge E;
  - required: `write_or_not`=1 after E with `ROB_BYPASS_EN` defined, after E+1 without it.

Source files
------------

// File: rtl/rob_commit.sv
// In-order commit buffer: allocates in program order, completes out of order, retires one entry per cycle.
// Optional same-edge head bypass is enabled by defining ROB_BYPASS_EN.
`timescale 1ns/1ps
module rob_commit #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             flush,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cmpl_valid,
    input  logic [TAG_W-1:0] cmpl_tag,
    input  logic [31:0]      cmpl_data,
    output logic             write_or_not,
    output logic [4:0]       writeaddr,
    output logic [31:0]      writedata,
    output logic             commit_valid,
    output logic [TAG_W:0]   count
);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] rdy;
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;

    logic        do_alloc;
    logic        do_cmpl;
    logic        byp_p0;
    logic        vld_p0;
    logic [4:0]  rd_p0;
    logic [31:0] data_p0;

    // Full is judged on the registered count only; a same-cycle retire does not free a slot early.
    assign alloc_ready = (count != (TAG_W+1)'(DEPTH));
    assign alloc_tag   = tail;

    // Stage p0: decide this cycle's alloc, completion and retire from the current entry state.
    always_comb begin
        do_alloc = alloc_valid && alloc_ready;
        do_cmpl  = cmpl_valid && busy[cmpl_tag] && !rdy[cmpl_tag];
`ifdef ROB_BYPASS_EN
        byp_p0   = do_cmpl && (cmpl_tag == head);
`else
        byp_p0   = 1'b0;
`endif
        vld_p0   = (busy[head] && rdy[head]) || byp_p0;
        rd_p0    = rd_mem[head];
        data_p0  = byp_p0 ? cmpl_data : data_mem[head];
    end

    // Stage p1: entry bookkeeping and the registered register-file write port.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush) begin
            busy         <= '0;
            rdy          <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            write_or_not <= 1'b0;
            writeaddr    <= '0;
            writedata    <= '0;
        end else begin
            if (do_cmpl)
                rdy[cmpl_tag] <= 1'b1;
            // Retire after completion so a bypassed head ends up cleared, not left ready.
            if (vld_p0) begin
                busy[head] <= 1'b0;
                rdy[head]  <= 1'b0;
                head       <= head + TAG_W'(1);
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                rdy[tail]  <= 1'b0;
                tail       <= tail + TAG_W'(1);
            end
            count        <= count + (TAG_W+1)'(do_alloc) - (TAG_W+1)'(vld_p0);
            commit_valid <= vld_p0;
            write_or_not <= vld_p0 && (rd_p0 != 5'd0);
            writeaddr    <= vld_p0 ? rd_p0 : 5'd0;
            writedata    <= vld_p0 ? data_p0 : 32'd0;
        end
    end

    // Payload storage carries no reset; busy/ready qualify every read.
    always_ff @(posedge clk_in) begin
        if (do_cmpl)
            data_mem[cmpl_tag] <= cmpl_data;
        if (do_alloc)
            rd_mem[tail] <= alloc_rd;
    end

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a program-order queue model predicts every retire and the occupancy.
`timescale 1ns/1ps
module tb_rob_commit;
    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk_in = 1'b0;
    logic             rst_in, flush, alloc_valid, cmpl_valid;
    logic [4:0]       alloc_rd;
    logic [TAG_W-1:0] cmpl_tag;
    logic [31:0]      cmpl_data;
    logic             alloc_ready, write_or_not, commit_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic [4:0]       writeaddr;
    logic [31:0]      writedata;
    logic [TAG_W:0]   count;

    rob_commit #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
        .write_or_not(write_or_not), .writeaddr(writeaddr), .writedata(writedata),
        .commit_valid(commit_valid), .count(count)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          done;
    } ent_t;

    ent_t       ent[$];          // outstanding instructions, oldest first
    int         mtail = 0;       // tag the next allocation will receive
    int         ncmp = 0, nerr = 0, cyc = 0;
    bit         mon_en = 1'b0;
    int         wlog_cyc[$];
    logic [4:0] wlog_rd[$];

    always @(posedge clk_in) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int head_tag();
        return (mtail - ent.size() + DEPTH) % DEPTH;
    endfunction

    function automatic int pick_pending();
        int cand[$];
        for (int p = 0; p < ent.size(); p++)
            if (!ent[p].done) cand.push_back(p);
        if (cand.size() == 0) return -1;
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    // Monitor: every retire must be the oldest outstanding instruction with its completed value.
    initial begin
        ent_t e;
        forever begin
            @(negedge clk_in);
            if (mon_en) begin
                if (commit_valid === 1'b1) begin
                    if (ent.size() == 0) begin
                        chk("spurious_commit", 32'd1, 32'd0);
                    end else begin
                        e = ent.pop_front();
                        chk("commit_completed", 32'(e.done), 32'd1);
                        chk("writeaddr", 32'(writeaddr), 32'(e.rd));
                        chk("writedata", writedata, e.data);
                        chk("write_or_not", 32'(write_or_not), 32'(e.rd != 5'd0));
                        wlog_cyc.push_back(cyc);
                        wlog_rd.push_back(writeaddr);
                    end
                end else begin
                    chk("commit_valid_low", 32'(commit_valid), 32'd0);
                    chk("idle_outputs", writedata | 32'(writeaddr) | 32'(write_or_not), 32'd0);
                end
            end
        end
    end

    // Drive one cycle (fl: 0 none, 1 flush, 2 reset), advance the model, then check occupancy after the edge.
    task automatic step(input bit av, input logic [4:0] ard, input bit cv, input int ct,
                        input logic [31:0] cd, input int fl);
        alloc_valid = av; alloc_rd = ard;
        cmpl_valid  = cv; cmpl_tag = TAG_W'(ct); cmpl_data = cd;
        flush = (fl == 1); rst_in = (fl == 2);
        if (fl != 0) begin
            ent.delete();
            mtail = 0;
        end else begin
            if (cv) begin
                int p;
                ent_t t;
                p = (ct - head_tag() + DEPTH) % DEPTH;
                if (p < ent.size() && !ent[p].done) begin
                    t = ent[p]; t.data = cd; t.done = 1'b1; ent[p] = t;
                end
            end
            if (av && ent.size() < DEPTH) begin
                chk("alloc_tag_on_alloc", 32'(alloc_tag), 32'(mtail));
                ent.push_back('{ard, 32'd0, 1'b0});
                mtail = (mtail + 1) % DEPTH;
            end
        end
        @(negedge clk_in); #1;
        chk("count", 32'(count), 32'(ent.size()));
        chk("alloc_ready", 32'(alloc_ready), 32'(ent.size() != DEPTH));
        chk("alloc_tag", 32'(alloc_tag), 32'(mtail));
    endtask

    task automatic idle();
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 0);
    endtask

    task automatic drain();
        for (int g = 0; g < 4 * DEPTH; g++) begin
            int p;
            p = pick_pending();
            if (p < 0) break;
            step(1'b0, 5'd0, 1'b1, (head_tag() + p) % DEPTH, $urandom, 0);
        end
        for (int g = 0; g < 3 * DEPTH && ent.size() != 0; g++) idle();
        chk("drain_empty", 32'(ent.size()), 32'd0);
        chk("drain_count", 32'(count), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, base;
        rst_in = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_rd = 5'd0;
        cmpl_valid = 1'b0; cmpl_tag = '0; cmpl_data = 32'd0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in); #1;
        rst_in = 1'b0;
        chk("rst_write_or_not", 32'(write_or_not), 32'd0);
        chk("rst_writeaddr", 32'(writeaddr), 32'd0);
        chk("rst_writedata", writedata, 32'd0);
        chk("rst_commit_valid", 32'(commit_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        mon_en = 1'b1;

        // Out-of-order completion, in-order retire.
        wlog_cyc.delete(); wlog_rd.delete();
        step(1'b1, 5'd1, 1'b0, 0, 32'd0, 0);
        step(1'b1, 5'd2, 1'b0, 0, 32'd0, 0);
        step(1'b1, 5'd3, 1'b0, 0, 32'd0, 0);
        step(1'b0, 5'd0, 1'b1, 2, 32'h33, 0);
        step(1'b0, 5'd0, 1'b1, 0, 32'h11, 0);
        step(1'b0, 5'd0, 1'b1, 1, 32'h22, 0);
        repeat (5) idle();
        chk("ooo_commit_count", 32'(wlog_rd.size()), 32'd3);
        if (wlog_rd.size() == 3) begin
            chk("ooo_order_0", 32'(wlog_rd[0]), 32'd1);
            chk("ooo_order_1", 32'(wlog_rd[1]), 32'd2);
            chk("ooo_order_2", 32'(wlog_rd[2]), 32'd3);
            chk("ooo_back_to_back", 32'(wlog_cyc[2] - wlog_cyc[1]), 32'd1);
        end

        // Full, ignored alloc, release and wrap to tag 0.
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 1);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 5'($urandom_range(1, 31)), 1'b0, 0, 32'd0, 0);
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_ready", 32'(alloc_ready), 32'd0);
        step(1'b1, 5'd9, 1'b0, 0, 32'd0, 0);
        chk("full_alloc_ignored", 32'(count), 32'(DEPTH));
        step(1'b0, 5'd0, 1'b1, 0, 32'hAB, 0);
        n = 0;
        while (count == (TAG_W+1)'(DEPTH) && n < 4) begin idle(); n++; end
        chk("full_release_delay", 32'(n), BYP ? 32'd0 : 32'd1);
        chk("ready_after_commit", 32'(alloc_ready), 32'd1);
        chk("wrap_tag", 32'(alloc_tag), 32'd0);
        step(1'b1, 5'd5, 1'b0, 0, 32'd0, 0);
        drain();

        // Flush with a completed head pending.
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 1);
        for (int i = 0; i < 5; i++) step(1'b1, 5'(i + 10), 1'b0, 0, 32'd0, 0);
        step(1'b0, 5'd0, 1'b1, 0, 32'h1234, 0);
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 1);
        chk("flush_no_write", 32'(write_or_not), 32'd0);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_tag", 32'(alloc_tag), 32'd0);
        step(1'b1, 5'd4, 1'b1, 3, 32'hBAD, 0);
        for (int i = 0; i < 3; i++) step(1'b1, 5'(i + 20), 1'b0, 0, 32'd0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b1, i, 32'(i + 100), 0);
        repeat (3) idle();
        chk("stale_cmpl_ignored", 32'(count), 32'd1);
        drain();

        // rd=0 retires without a register-file write.
        base = wlog_rd.size();
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 1);
        step(1'b1, 5'd0, 1'b0, 0, 32'd0, 0);
        step(1'b0, 5'd0, 1'b1, 0, 32'hDEAD, 0);
        repeat (2) idle();
        chk("rd0_retired", 32'(wlog_rd.size() - base), 32'd1);

        // Head completion latency.
        step(1'b0, 5'd0, 1'b0, 0, 32'd0, 1);
        step(1'b1, 5'd7, 1'b0, 0, 32'd0, 0);
        idle();
        step(1'b0, 5'd0, 1'b1, 0, 32'h77, 0);
        chk("latency_after_E", 32'(write_or_not), 32'(BYP));
        idle();
        chk("latency_after_E1", 32'(write_or_not), 32'(!BYP));
        drain();

        // Randomized traffic with occasional flush and mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            int r, fl, p, tg;
            bit av, cv;
            r  = $urandom_range(0, 99);
            fl = (r < 2) ? 1 : (r < 3) ? 2 : 0;
            av = ($urandom_range(0, 99) < 60);
            cv = ($urandom_range(0, 99) < 55);
            p  = pick_pending();
            if (p >= 0 && $urandom_range(0, 99) < 85) tg = (head_tag() + p) % DEPTH;
            else tg = $urandom_range(0, DEPTH - 1);
            step(av, 5'($urandom_range(0, 31)), cv, tg, $urandom, fl);
        end
        idle();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
